logicnet_lut_layer: RTL and testbench

LOGICNET_LUT_LAYER -- requirements
Module: logicnet_lut_layer

---
 rtl/logicnet_pkg.sv | 11 +
 rtl/logicnet_lut_table.sv | 20 ++
 rtl/logicnet_lut_layer.sv | 96 +++++++++
 tb/tb_logicnet_lut_layer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/logicnet_pkg.sv
// logicnet_pkg: FSM state encoding shared by the LUT layer
package logicnet_pkg;
  typedef enum logic [1:0] {
    ST_CFG   = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;
  localparam logic [1:0] MODE_CFG   = 2'd0;
  localparam logic [1:0] MODE_RUN   = 2'd1;
  localparam logic [1:0] MODE_DRAIN = 2'd2;
endpackage

// File: rtl/logicnet_lut_table.sv
// logicnet_lut_table: one neuron truth table with a write port and combinational read
module logicnet_lut_table #(
  parameter int IN_BITS  = 8,
  parameter int OUT_BITS = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we_i,
  input  logic [IN_BITS-1:0]  waddr_i,
  input  logic [OUT_BITS-1:0] wdata_i,
  input  logic [IN_BITS-1:0]  raddr_i,
  output logic [OUT_BITS-1:0] rdata_o
);
  (* rom_style = "distributed" *) logic [OUT_BITS-1:0] mem_q [2**IN_BITS];
  // Entry write; reset clears every entry so an uncommitted table reads zero
  always_ff @(posedge clk or posedge rst)
    if (rst) mem_q <= '{default: '0};
    else if (we_i) mem_q[waddr_i] <= wdata_i;
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/logicnet_lut_layer.sv
// logicnet_lut_layer: layer of independent LUT neurons behind a CFG/RUN/DRAIN access FSM
module logicnet_lut_layer
  import logicnet_pkg::*;
#(
  parameter int N_NEURONS = 4,
  parameter int IN_BITS   = 8,
  parameter int OUT_BITS  = 1,
  parameter int IN_REG    = 0
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        in_valid,
  output logic                                        in_ready,
  input  logic [N_NEURONS*IN_BITS-1:0]                in_data,
  output logic                                        out_valid,
  input  logic                                        out_ready,
  output logic [N_NEURONS*OUT_BITS-1:0]               out_data,
  input  logic                                        cfg_we,
  input  logic [(N_NEURONS > 1 ? $clog2(N_NEURONS) : 1)-1:0] cfg_neuron,
  input  logic [IN_BITS-1:0]                          cfg_addr,
  input  logic [OUT_BITS-1:0]                         cfg_data,
  input  logic                                        cfg_commit,
  input  logic                                        cfg_unlock,
  output logic                                        cfg_err,
  output logic [1:0]                                  mode
);
  localparam int NW = N_NEURONS > 1 ? $clog2(N_NEURONS) : 1;
  state_e state_q, state_d;
  logic out_valid_q, out_valid_d, s1_valid_q, s1_valid_d, cfg_err_q;
  logic run, accept, out_adv, load_out, tbl_we;
  logic [N_NEURONS*IN_BITS-1:0]  rd_addr;
  logic [N_NEURONS*OUT_BITS-1:0] lut_out, out_data_q;
  assign run     = state_q == ST_RUN;
  assign out_adv = !out_valid_q || out_ready;
  assign accept  = in_valid && in_ready;
  assign tbl_we  = cfg_we && state_q == ST_CFG;
  for (genvar n = 0; n < N_NEURONS; n++) begin : g_lut
    logicnet_lut_table #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) u_lut (
      .clk     (clk),
      .rst     (rst),
      .we_i    (tbl_we && cfg_neuron == NW'(n)),
      .waddr_i (cfg_addr),
      .wdata_i (cfg_data),
      .raddr_i (rd_addr[n*IN_BITS +: IN_BITS]),
      .rdata_o (lut_out[n*OUT_BITS +: OUT_BITS])
    );
  end
  if (IN_REG != 0) begin : g_in_reg
    logic [N_NEURONS*IN_BITS-1:0] s1_data_q;
    // Input stage: holds each accepted vector until the lookup stage can take it
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        s1_valid_q <= 1'b0;
        s1_data_q  <= '0;
      end else begin
        s1_valid_q <= s1_valid_d;
        if (accept) s1_data_q <= in_data;
      end
    assign rd_addr  = s1_data_q;
    assign load_out = s1_valid_q && out_adv;
    assign in_ready = run && (!s1_valid_q || out_adv);
  end else begin : g_no_in_reg
    assign s1_valid_q = 1'b0;
    assign rd_addr    = in_data;
    assign load_out   = accept;
    assign in_ready   = run && out_adv;
  end
  // Pipeline valids and next state; unlock with anything in flight detours through DRAIN
  always_comb begin
    s1_valid_d  = (IN_REG != 0) && (accept || (s1_valid_q && !out_adv));
    out_valid_d = load_out || (out_valid_q && !out_ready);
    state_d = state_q == ST_CFG ? (cfg_commit ? ST_RUN : ST_CFG)
            : state_q == ST_RUN ? (!cfg_unlock ? ST_RUN
                                  : (out_valid_q || s1_valid_q || accept) ? ST_DRAIN : ST_CFG)
            : (out_valid_d || s1_valid_d) ? ST_DRAIN : ST_CFG;
  end
  // FSM state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= ST_CFG;
    else state_q <= state_d;
  // Output stage and rejected-write pulse
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      cfg_err_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      cfg_err_q   <= cfg_we && state_q != ST_CFG;
      if (load_out) out_data_q <= lut_out;
    end
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign cfg_err   = cfg_err_q;
  assign mode      = state_q;
endmodule

// File: tb/tb_logicnet_lut_layer.sv
// tb_logicnet_lut_layer: randomized checks of two layer configurations against a table model
module tb_logicnet_lut_layer;
  logic clk = 1'b0, rst = 1'b1, sel = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b0, cfg_we = 1'b0, cfg_commit = 1'b0, cfg_unlock = 1'b0;
  logic [47:0] in_data = '0;
  logic [2:0]  cfg_neuron = '0;
  logic [7:0]  cfg_addr = '0;
  logic [1:0]  cfg_data = '0;
  logic ra, ova, erra, rb, ovb, errb;
  logic [3:0]  oda;
  logic [15:0] odb;
  logic [1:0]  mda, mdb;
  logic rdy, ov, err;
  logic [15:0] od;
  logic [1:0]  md;
  int checks = 0, errors = 0, nn, ib, ob, lat;
  logic [1:0] mdl [8][256];

  always #5 clk = ~clk;

  logicnet_lut_layer dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid && !sel), .in_ready(ra), .in_data(in_data[31:0]),
    .out_valid(ova), .out_ready(out_ready), .out_data(oda), .cfg_we(cfg_we && !sel),
    .cfg_neuron(cfg_neuron[1:0]), .cfg_addr(cfg_addr), .cfg_data(cfg_data[0:0]),
    .cfg_commit(cfg_commit && !sel), .cfg_unlock(cfg_unlock && !sel), .cfg_err(erra), .mode(mda));

  logicnet_lut_layer #(.N_NEURONS(8), .IN_BITS(6), .OUT_BITS(2), .IN_REG(1)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid && sel), .in_ready(rb), .in_data(in_data),
    .out_valid(ovb), .out_ready(out_ready), .out_data(odb), .cfg_we(cfg_we && sel),
    .cfg_neuron(cfg_neuron), .cfg_addr(cfg_addr[5:0]), .cfg_data(cfg_data),
    .cfg_commit(cfg_commit && sel), .cfg_unlock(cfg_unlock && sel), .cfg_err(errb), .mode(mdb));

  assign rdy = sel ? rb : ra;
  assign ov  = sel ? ovb : ova;
  assign err = sel ? errb : erra;
  assign md  = sel ? mdb : mda;
  assign od  = sel ? odb : {12'b0, oda};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s (cfg %0d) got %h expected %h", tag, sel, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [47:0] rnd();
    return {16'($urandom), $urandom};
  endfunction

  // Each neuron looks up its own address field in its table; results packed at n*ob
  function automatic logic [15:0] exp_vec(input logic [47:0] d);
    logic [15:0] r = '0;
    for (int n = 0; n < nn; n++) begin
      int a = int'((d >> (n * ib)) & ((48'd1 << ib) - 48'd1));
      r |= 16'(mdl[n][a]) << (n * ob);
    end
    return r;
  endfunction

  task automatic do_reset();
    rst = 1'b1; in_valid = 0; out_ready = 0; cfg_we = 0; cfg_commit = 0; cfg_unlock = 0;
    foreach (mdl[i, j]) mdl[i][j] = '0;
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_mode", md, 0);
    chk("reset_out_valid", ov, 0);
    chk("reset_in_ready", rdy, 0);
    chk("reset_cfg_err", err, 0);
    chk("reset_out_data", od, 0);
    tick();
  endtask

  // Fill every table; the final write shares its cycle with the commit
  task automatic load_tables();
    for (int n = 0; n < nn; n++)
      for (int a = 0; a < (1 << ib); a++) begin
        int v = sel ? int'($urandom_range(0, 3)) : (n == 0 ? int'($countones(8'(a)) >= 4) : (a & 1));
        cfg_we = 1; cfg_neuron = 3'(n); cfg_addr = 8'(a); cfg_data = 2'(v);
        cfg_commit = (n == nn - 1) && (a == (1 << ib) - 1);
        mdl[n][a] = 2'(v) & 2'((1 << ob) - 1);
        tick();
      end
    cfg_we = 0; cfg_commit = 0;
    @(negedge clk) chk("commit_mode_run", md, 1);
    tick();
  endtask

  task automatic send_one(input logic [47:0] d, input string tag);
    int c;
    in_valid = 1; in_data = d; out_ready = 1;
    @(negedge clk) chk({tag, "_in_ready"}, rdy, 1);
    tick();
    in_valid = 0;
    c = 1;
    @(negedge clk);
    while (!ov && c < 8) begin tick(); @(negedge clk); c++; end
    chk({tag, "_latency"}, c, lat);
    chk({tag, "_data"}, od, exp_vec(d));
    tick();
    out_ready = 0;
  endtask

  task automatic stream(input int nvec);
    logic [15:0] q[$];
    logic [15:0] held = '0;
    logic stalled = 0, acc;
    int sent = 0, got = 0, cyc = 0;
    in_data = rnd();
    while (got < nvec && cyc < 5000) begin
      in_valid = sent < nvec;
      out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      @(negedge clk);
      if (stalled) begin chk("stall_valid", ov, 1); chk("stall_data", od, held); end
      if (ov && out_ready) begin
        chk("stream_have_expected", q.size() != 0, 1);
        if (q.size() != 0) chk("stream_data", od, q.pop_front());
        got++;
      end
      acc = in_valid && rdy;
      if (acc) begin q.push_back(exp_vec(in_data)); sent++; end
      stalled = ov && !out_ready;
      held = od;
      tick();
      if (acc) in_data = rnd();
      cyc++;
    end
    in_valid = 0; out_ready = 0;
    chk("stream_count", got, nvec);
    chk("stream_drained", q.size(), 0);
    @(negedge clk) chk("stream_no_extra", ov, 0);
    tick();
  endtask

  task automatic run_cfg(input logic s);
    logic [47:0] d;
    logic [15:0] e;
    logic [1:0] old;
    int c;
    sel = s; nn = s ? 8 : 4; ib = s ? 6 : 8; ob = s ? 2 : 1; lat = s ? 2 : 1;
    do_reset();
    load_tables();
    send_one(s ? rnd() : 48'h0F01FF00, "directed");
    stream(256);
    // Write attempt while running must be refused
    old = mdl[2][5];
    cfg_we = 1; cfg_neuron = 3'd2; cfg_addr = 8'd5; cfg_data = ~old;
    tick();
    cfg_we = 0;
    @(negedge clk) chk("cfg_err_pulse", err, 1);
    tick();
    @(negedge clk) chk("cfg_err_clear", err, 0);
    tick();
    d = rnd();
    d[2*ib +: 8] = 8'h05;
    send_one(d, "locked_read");
    // Unlock with an output stalled downstream
    d = rnd(); e = exp_vec(d);
    in_valid = 1; in_data = d; out_ready = 0;
    @(negedge clk) chk("drain_accept", rdy, 1);
    tick();
    in_valid = 0;
    c = 0;
    @(negedge clk);
    while (!ov && c < 8) begin tick(); @(negedge clk); c++; end
    chk("drain_out_valid", ov, 1);
    cfg_unlock = 1;
    tick();
    cfg_unlock = 0;
    repeat (3) begin
      @(negedge clk);
      chk("drain_mode", md, 2);
      chk("drain_in_ready", rdy, 0);
      chk("drain_hold_data", od, e);
      tick();
    end
    out_ready = 1;
    @(negedge clk) chk("drain_last_mode", md, 2);
    tick();
    out_ready = 0;
    @(negedge clk);
    chk("drain_to_cfg", md, 0);
    chk("drain_empty", ov, 0);
    tick();
    // Reset with the pipeline full
    cfg_commit = 1;
    tick();
    cfg_commit = 0;
    @(negedge clk) chk("recommit_mode", md, 1);
    tick();
    in_valid = 1; in_data = rnd();
    tick(); in_data = rnd();
    tick(); in_data = rnd();
    tick();
    in_valid = 0;
    @(negedge clk) chk("full_out_valid", ov, 1);
    #1 rst = 1;
    #1;
    chk("async_rst_out_valid", ov, 0);
    chk("async_rst_mode", md, 0);
    chk("async_rst_in_ready", rdy, 0);
    chk("async_rst_out_data", od, 0);
    tick();
    rst = 0;
    foreach (mdl[i, j]) mdl[i][j] = '0;
    repeat (3) begin @(negedge clk) chk("post_rst_idle", ov, 0); tick(); end
    cfg_commit = 1;
    tick();
    cfg_commit = 0;
    send_one(rnd(), "cleared_read");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    run_cfg(1'b0);
    run_cfg(1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
